// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the CPU core.
//   XLEN       - register data width
//   REG_ADDR_W - register index width
//   NUM_REGS   - architectural register count
//   REG_ZERO   - index of the hard-wired zero register
//   grant_e    - write-port arbitration result
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_MEM  = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small synchronous FIFO with asynchronous reset.
// The head entry is visible combinationally so a result pushed at one edge
// can be popped on the very next edge.
// Ports:
//   clk, reset      - clock, async active-high reset (empties the FIFO)
//   push, push_data - write request and payload (ignored when full)
//   pop             - remove the head entry (ignored when empty)
//   full, empty     - occupancy flags
//   head            - oldest entry
module wb_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results (direct) and load results (buffered)
// into one registered register-file write port, and keeps a per-register
// pending-write scoreboard for the hazard logic.
// Ports:
//   clk, reset                     - clock, async active-high reset
//   issue_valid/issue_rd/issue_ready - reserve a destination as pending
//   alu_valid/alu_rd/alu_data/alu_ready - ALU result handshake
//   mem_valid/mem_rd/mem_data/mem_ready - load result handshake
//   query_rs1/query_rs2, rs1_busy/rs2_busy - combinational hazard query
//   wb_rd/wb_data/wb_we            - register file write port
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int MEM_FIFO_DEPTH = 2,
    parameter int XLEN           = cpu_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] query_rs1,
    input  logic [REG_ADDR_W-1:0] query_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_we
);

    localparam int ENTRY_W = REG_ADDR_W + XLEN;

    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;
    logic [REG_ADDR_W-1:0] wb_rd_reg;
    logic [XLEN-1:0]       wb_data_reg;
    logic                  wb_we_reg;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;

    grant_e                grant;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [XLEN-1:0]       grant_data;
    logic                  grant_writes;

    wb_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (MEM_FIFO_DEPTH)
    ) u_mem_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_valid && mem_ready),
        .push_data ({mem_rd, mem_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign head_rd   = fifo_head[XLEN +: REG_ADDR_W];
    assign head_data = fifo_head[XLEN-1:0];

    // Both readies depend only on FIFO state, never on the port's own valid.
    // A full FIFO takes the port so the load path cannot starve.
    assign mem_ready = !fifo_full;
    assign alu_ready = !fifo_full;

    always_comb begin
        grant      = GRANT_NONE;
        grant_rd   = REG_ZERO;
        grant_data = '0;
        if (fifo_full) begin
            grant      = GRANT_MEM;
            grant_rd   = head_rd;
            grant_data = head_data;
        end else if (alu_valid) begin
            grant      = GRANT_ALU;
            grant_rd   = alu_rd;
            grant_data = alu_data;
        end else if (!fifo_empty) begin
            grant      = GRANT_MEM;
            grant_rd   = head_rd;
            grant_data = head_data;
        end
    end

    // An x0 result is still consumed (popped) but never reaches the port.
    assign fifo_pop     = (grant == GRANT_MEM);
    assign grant_writes = (grant != GRANT_NONE) && (grant_rd != REG_ZERO);

    // Readiness uses the current busy bit, so a register whose bit is being
    // cleared by this cycle's write is still refused until the next cycle.
    assign issue_ready = !busy_reg[issue_rd] || (issue_rd == REG_ZERO);

    always_comb begin
        busy_next = busy_reg;
        if (wb_we_reg) begin
            busy_next[wb_rd_reg] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != REG_ZERO)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg    <= '0;
            wb_we_reg   <= 1'b0;
            wb_rd_reg   <= '0;
            wb_data_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            wb_we_reg <= grant_writes;
            if (grant_writes) begin
                wb_rd_reg   <= grant_rd;
                wb_data_reg <= grant_data;
            end
        end
    end

    assign rs1_busy = busy_reg[query_rs1];
    assign rs2_busy = busy_reg[query_rs2];
    assign wb_rd    = wb_rd_reg;
    assign wb_data  = wb_data_reg;
    assign wb_we    = wb_we_reg;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;

    int vectors    = 0;
    int miscompares = 0;

    // Random-phase reference: one outstanding result per reserved register.
    bit          rand_phase = 1'b0;
    bit          pend [32];
    logic [31:0] exp_data [32];
    int          sent = 0;
    int          writes_seen = 0;

    writeback_unit #(
        .MEM_FIFO_DEPTH (2),
        .XLEN           (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .query_rs1   (query_rs1),
        .query_rs2   (query_rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_we       (wb_we)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scores every write-port pulse during the random phase.
    always @(negedge clk) begin
        if (rand_phase && wb_we) begin
            $display("wb write rd=%0d data=%h", wb_rd, wb_data);
            check_value("wb_expected", {31'd0, pend[wb_rd]}, 32'd1);
            if (pend[wb_rd]) begin
                check_value("wb_data", wb_data, exp_data[wb_rd]);
                pend[wb_rd] = 1'b0;
            end
            writes_seen++;
        end
    end

    task automatic pick_free(output logic [4:0] r);
        int tries;
        tries = 0;
        r = 5'($urandom_range(31, 1));
        while (pend[r] && tries < 200) begin
            r = 5'($urandom_range(31, 1));
            tries++;
        end
    endtask

    task automatic do_issue(input logic [4:0] r, input logic [31:0] d);
        issue_valid = 1'b1;
        issue_rd    = r;
        #1;
        check_value("rnd_issue_ready", {31'd0, issue_ready}, 32'd1);
        pend[r]     = 1'b1;
        exp_data[r] = d;
        sent++;
        tick();
        issue_valid = 1'b0;
        query_rs1   = r;
        #1;
        check_value("rnd_busy_set", {31'd0, rs1_busy}, 32'd1);
    endtask

    logic [4:0]  ra, rm;
    logic [31:0] da, dm;
    bit          use_a, use_m, a_pend, m_pend, a_acc, m_acc;
    int          budget, k, a_idx, m_idx, pend_left;
    bit          exp_rdy [6] = '{1, 1, 0, 1, 0, 1};
    logic [4:0]  exp_rd  [6] = '{5'd10, 5'd11, 5'd20, 5'd12, 5'd21, 5'd13};

    function automatic logic [31:0] t4_data(input logic [4:0] r);
        return (r < 5'd20) ? (32'hA000_0000 | {27'd0, r}) : (32'hB000_0000 | {27'd0, r});
    endfunction

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        query_rs1 = '0; query_rs2 = '0;
        for (int i = 0; i < 32; i++) begin
            pend[i] = 1'b0;
            exp_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check_value("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check_value("rst_wb_data", wb_data, 32'd0);
        check_value("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        check_value("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Reserve x5, ALU write to x5, WAW stall on re-issue.
        $display("txn: issue x5, alu x5 <- deadbeef");
        issue_valid = 1'b1; issue_rd = 5'd5; query_rs1 = 5'd5;
        #1;
        check_value("issue5_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        check_value("busy5_set", {31'd0, rs1_busy}, 32'd1);
        check_value("reissue5_blocked", {31'd0, issue_ready}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        check_value("alu5_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        check_value("alu5_wb_we", {31'd0, wb_we}, 32'd1);
        check_value("alu5_wb_rd", {27'd0, wb_rd}, 32'd5);
        check_value("alu5_wb_data", wb_data, 32'hDEAD_BEEF);
        check_value("waw_still_blocked", {31'd0, issue_ready}, 32'd0);
        check_value("busy5_until_edge", {31'd0, rs1_busy}, 32'd1);
        tick();
        check_value("busy5_cleared", {31'd0, rs1_busy}, 32'd0);
        check_value("reissue5_ready", {31'd0, issue_ready}, 32'd1);
        check_value("idle_wb_we", {31'd0, wb_we}, 32'd0);
        check_value("idle_wb_rd_hold", {27'd0, wb_rd}, 32'd5);
        tick();
        issue_valid = 1'b0;
        #1;
        check_value("busy5_reset_again", {31'd0, rs1_busy}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0055;
        tick();
        alu_valid = 1'b0;
        tick();
        check_value("busy5_cleared2", {31'd0, rs1_busy}, 32'd0);

        // x0 is never reserved nor written.
        $display("txn: issue x0, alu x0 <- 1234");
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check_value("issue0_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0; query_rs1 = 5'd0;
        #1;
        check_value("busy0_zero", {31'd0, rs1_busy}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        tick();
        alu_valid = 1'b0;
        #1;
        check_value("alu0_no_we", {31'd0, wb_we}, 32'd0);
        check_value("alu0_data_hold", wb_data, 32'h0000_0055);

        // Simultaneous ALU x3 and load x4.
        $display("txn: alu x3 + load x4 together");
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0; query_rs2 = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h4444_4444;
        #1;
        check_value("sim_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_value("sim_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_value("sim_first_rd", {27'd0, wb_rd}, 32'd3);
        check_value("sim_first_we", {31'd0, wb_we}, 32'd1);
        check_value("sim_rs2_busy_a", {31'd0, rs2_busy}, 32'd1);
        tick();
        check_value("sim_second_rd", {27'd0, wb_rd}, 32'd4);
        check_value("sim_second_data", wb_data, 32'h4444_4444);
        check_value("sim_rs2_busy_b", {31'd0, rs2_busy}, 32'd1);
        tick();
        check_value("sim_done_we", {31'd0, wb_we}, 32'd0);
        check_value("sim_rs2_free", {31'd0, rs2_busy}, 32'd0);

        // Both ports streaming: FIFO fills every other cycle and drains.
        $display("txn: stream alu+load, fifo fill");
        a_idx = 0; m_idx = 0;
        for (k = 0; k < 6; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + a_idx); alu_data = t4_data(5'(10 + a_idx));
            mem_valid = 1'b1; mem_rd = 5'(20 + m_idx); mem_data = t4_data(5'(20 + m_idx));
            #1;
            check_value("fill_alu_ready", {31'd0, alu_ready}, {31'd0, exp_rdy[k]});
            check_value("fill_mem_ready", {31'd0, mem_ready}, {31'd0, exp_rdy[k]});
            a_acc = alu_ready; m_acc = mem_ready;
            tick();
            if (a_acc) a_idx++;
            if (m_acc) m_idx++;
            check_value("fill_wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd[k]});
            check_value("fill_wb_data", wb_data, t4_data(exp_rd[k]));
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        check_value("drain_rd22", {27'd0, wb_rd}, 32'd22);
        tick();
        check_value("drain_rd23", {27'd0, wb_rd}, 32'd23);
        check_value("drain_we23", {31'd0, wb_we}, 32'd1);
        tick();
        check_value("drain_idle", {31'd0, wb_we}, 32'd0);
        check_value("drain_mem_ready", {31'd0, mem_ready}, 32'd1);

        // Asynchronous reset with two loads buffered and x5 reserved.
        $display("txn: reset mid-stream");
        issue_valid = 1'b1; issue_rd = 5'd5; query_rs1 = 5'd5;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h8;
        tick();
        mem_rd = 5'd9; mem_data = 32'h9;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check_value("pre_rst_full", {31'd0, mem_ready}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check_value("arst_wb_we", {31'd0, wb_we}, 32'd0);
        check_value("arst_mem_ready", {31'd0, mem_ready}, 32'd1);
        check_value("arst_busy5", {31'd0, rs1_busy}, 32'd0);
        check_value("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_value("arst_discarded", {31'd0, wb_we}, 32'd0);

        // Random interleaving against the reference.
        rand_phase = 1'b1;
        for (int it = 0; it < 250; it++) begin
            use_a = bit'($urandom_range(1, 0));
            use_m = !use_a || bit'($urandom_range(1, 0));
            if (use_a) begin
                pick_free(ra);
                da = $urandom;
                do_issue(ra, da);
            end
            if (use_m) begin
                pick_free(rm);
                dm = $urandom;
                do_issue(rm, dm);
            end
            a_pend = use_a; m_pend = use_m;
            budget = 0;
            while ((a_pend || m_pend) && budget < 50) begin
                alu_valid = a_pend; alu_rd = ra; alu_data = da;
                mem_valid = m_pend; mem_rd = rm; mem_data = dm;
                #1;
                a_acc = a_pend && alu_ready;
                m_acc = m_pend && mem_ready;
                tick();
                if (a_acc) a_pend = 1'b0;
                if (m_acc) m_pend = 1'b0;
                budget++;
            end
            alu_valid = 1'b0; mem_valid = 1'b0;
            if (a_pend || m_pend) begin
                check_value("rnd_handshake_timeout", 32'd1, 32'd0);
                break;
            end
            // Occasionally idle so the FIFO drains at different depths.
            if ($urandom_range(3, 0) == 0) tick();
        end
        repeat (10) tick();
        rand_phase = 1'b0;
        check_value("rnd_write_count", writes_seen, sent);
        pend_left = 0;
        for (int i = 0; i < 32; i++) pend_left += int'(pend[i]);
        check_value("rnd_pending_left", pend_left, 32'd0);
        for (int i = 0; i < 32; i++) begin
            query_rs1 = 5'(i);
            #1;
            check_value("rnd_busy_final", {31'd0, rs1_busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
